// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - packs decoded instruction fields into 32-bit words
// and streams them into instruction memory, one write per accepted field set.
module instruction_encoder #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_last,
  input  logic [1:0]        i_fmt,
  input  logic              i_ext,
  input  logic [6:0]        i_opcode,
  input  logic [3:0]        i_dr,
  input  logic [3:0]        i_sa,
  input  logic [3:0]        i_sb,
  input  logic [15:0]       i_imm,
  input  logic [7:0]        i_ext8,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_done,
  output logic              o_full,
  output logic              o_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_done;
  logic              r_full;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_fill;
  logic [ADDR_W:0]   w_count_inc;
  logic [31:0]       w_packed;

  assign w_legal     = (i_fmt != 2'd3);
  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A start pulse wins over a same-cycle handshake, so accept is masked by it.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_fill       = 1'b0;
    if (r_state == S_LOAD && r_count < MAX_CNT) begin
      w_ready = 1'b1;
    end
    w_accept = i_valid & w_ready & ~i_start;
    w_fill   = w_legal && (w_count_inc == MAX_CNT);
    if (i_start) begin
      w_next_state = S_LOAD;
    end else if (w_accept && (i_last || w_fill)) begin
      w_next_state = S_DONE;
    end
  end

  always_comb begin
    w_packed = 32'h0000_0000;
    case (i_fmt)
      2'd0:    w_packed = {i_ext, 12'h000, i_opcode, i_dr, i_sa, i_sb};
      2'd1:    w_packed = {i_ext, i_imm[15:4], i_opcode, i_dr, i_sa, i_imm[3:0]};
      2'd2:    w_packed = {i_ext, 12'h000, i_opcode, i_ext8, i_sb};
      default: w_packed = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_we <= 1'b0;
      if (i_start) begin
        r_ptr   <= i_base_addr;
        r_count <= '0;
        r_done  <= 1'b0;
        r_full  <= 1'b0;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_packed;
          r_ptr   <= r_ptr + 1'b1;
          r_count <= w_count_inc;
        end else begin
          r_err <= 1'b1;
        end
        // Running out of room without a last marker ends the load as full.
        if (i_last) begin
          r_done <= 1'b1;
        end else if (w_fill) begin
          r_done <= 1'b1;
          r_full <= 1'b1;
        end
      end
    end
  end

  assign o_ready     = w_ready;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_count     = r_count;
  assign o_done      = r_done;
  assign o_full      = r_full;
  assign o_err       = r_err;

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs decoded instruction fields into 32-bit instruction words and writes them sequentially into instruction memory.
- Inverse of the instruction-register field split. Bit layout: [31] ext, [30:19] opr, [18:12] opcode (fs = [16:12]), [11:8] dr, [7:4] sa, [3:0] sb.
- Sits between the program loader / test sequencer and the instruction memory write port.
- Valid/ready input handshake; registered single-write-per-cycle output.

Parameters:
- ADDR_W, 8, instruction memory address width.
- MAX_WORDS, 256, words written per program before the block reports full; must be ≤ 2**ADDR_W.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle pulse; begins (or restarts) a program load at i_base_addr
- i_base_addr  in  ADDR_W  first write address, sampled on i_start
- i_valid  in  1  field set valid
- o_ready  out  1  block can accept a field set this cycle
- i_last  in  1  qualifies the final field set of a program
- i_fmt  in  2  0 register, 1 immediate, 2 extend, 3 illegal
- i_ext  in  1  extension bit
- i_opcode  in  7  opcode
- i_dr, i_sa, i_sb  in  4 each  register fields
- i_imm  in  16  immediate (fmt 1)
- i_ext8  in  8  extend byte (fmt 2)
- o_mem_we  out  1  memory write strobe
- o_mem_addr  out  ADDR_W  write address
- o_mem_wdata  out  32  packed word
- o_count  out  ADDR_W+1  words written since i_start
- o_done  out  1  load complete (held)
- o_full  out  1  MAX_WORDS reached without i_last
- o_err  out  1  sticky; an illegal fmt was received

Behaviour:
- Reset (async, i_rst=1): state IDLE; every output 0.
  - Covers o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_done, o_full, o_err.
  - Reset mid-load aborts with no further writes.
- FSM states: IDLE, LOAD, DONE.
- i_start in any state:
  - Next state LOAD; write pointer ← i_base_addr.
  - o_count, o_done, o_full, o_err ← 0.
  - i_start has priority over a same-cycle handshake; that field set is dropped.
- o_ready = 1 only in LOAD with o_count < MAX_WORDS. It is 0 in IDLE and DONE.
- Accept: i_valid & o_ready at edge N.
- Packing, by format:
  - fmt 0: {ext, 12'h000, opcode, dr, sa, sb}.
  - fmt 1: {ext, imm[15:4], opcode, dr, sa, imm[3:0]}; i_sb ignored.
  - fmt 2: {ext, 12'h000, opcode, ext8[7:4], ext8[3:0], sb}; i_dr and i_sa ignored.
  - fmt 3: no write; o_err set; pointer and count unchanged.
- Latency (legal fmt): o_mem_we = 1 for exactly the cycle after edge N, with o_mem_addr = pointer and o_mem_wdata = packed word.
  - Pointer then increments and wraps modulo 2**ADDR_W.
  - o_count increments in the same cycle o_mem_we is high.
- Back-to-back accepts give a continuous o_mem_we stream at one word per cycle.
- When o_mem_we = 0, o_mem_addr and o_mem_wdata hold their last values.
- i_last accepted:
  - Next state DONE; o_done = 1 from the cycle after acceptance, the same cycle as the final write.
  - Also applies with fmt 3: DONE with no write.
- Full:
  - When the write that brings o_count to MAX_WORDS is issued, o_ready drops that cycle.
  - If that word lacked i_last: o_full = 1 and state DONE.
  - If that word carried i_last: o_full = 0.
- DONE: o_done and o_full hold until i_start or reset; inputs are ignored.
- o_err persists through DONE until i_start or reset.

Test Plan:
1. Reset, i_start with base 8'h10, one fmt 0 word (ext=0, opcode=7'b0110000, dr=3, sa=1, sb=2, i_last=1).
   - One o_mem_we pulse, addr 0x10, data 0x00030312.
   - Next: o_done=1, o_count=1, o_ready=0.
2. fmt 1 word (ext=1, opcode=7'h05, dr=4, sa=6, imm=16'hABCD, i_sb=4'hF).
   - data 0xD5E0546D; fmt 2 (opcode=7'h10, ext8=8'h5A, sb=7) → data 0x000105A7.
3. Four back-to-back valid words from base 8'hFE.
   - o_mem_we high for 4 consecutive cycles; addrs FE, FF, 00, 01; o_count=4.
4. MAX_WORDS=4, six words offered, no i_last.
   - Exactly 4 writes; o_ready low after the 4th accept; o_full=1, o_done=1.
   - Then i_start → o_full=0, o_count=0, o_ready=1.
5. Middle word of three with fmt 3.
   - Two writes at consecutive addresses; o_err=1 held through DONE.
   - i_start while i_valid=1 → no write that cycle; o_err cleared.
6. i_rst asserted asynchronously during a write stream.
   - All outputs 0 immediately; after release o_ready=0 until i_start.
